csr_counter_unit: RTL and testbench

//   CSR-side responder for the machine counters (cycle, instret). Accepts CSR

---
 rtl/csr_counter_unit_if.sv | 23 ++
 rtl/csr_counter_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_csr_counter_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/csr_counter_unit_if.sv
// CSR request/response bus between the core's CSR datapath (master) and
// the counter unit (slave).
interface csr_counter_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_op, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/csr_counter_unit.sv
// Machine counter CSR responder (mcycle/minstret plus read-only 0xCxx
// aliases). Performs CSRRW/CSRRS/CSRRC on one 32-bit half per request and
// returns the old value two cycles after acceptance.
// Optional feature macro: MCOUNTINHIBIT_EN adds CSR 0x320 (CY bit0, IR bit2).
module csr_counter_unit #(
    parameter int               CNT_W     = 64,
    parameter logic [CNT_W-1:0] CYCLE_RST = '0
) (
    input  logic                clk,
    input  logic                reset,
    csr_counter_unit_if.slave   bus,
    input  logic                instret_inc
);

    localparam int HI_W = CNT_W - 32;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // read-modify-write result for the three write flavours
    function automatic logic [31:0] rmw_f(input logic [1:0]  op,
                                          input logic [31:0] old,
                                          input logic [31:0] opnd);
        logic [31:0] r;
        case (op)
            OP_RW:   r = opnd;
            OP_RS:   r = old | opnd;
            OP_RC:   r = old & ~opnd;
            default: r = old;
        endcase
        return r;
    endfunction

    // set/clear with a zero operand are pure reads
    function automatic logic is_write_f(input logic [1:0]  op,
                                        input logic [31:0] opnd);
        logic w;
        if (op == OP_RD)
            w = 1'b0;
        else if (op == OP_RW)
            w = 1'b1;
        else
            w = (opnd != 32'd0);
        return w;
    endfunction

    // upper counter half, zero-extended to a CSR word
    function automatic logic [31:0] hi_word_f(input logic [CNT_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[HI_W-1:0] = v[CNT_W-1:32];
        return r;
    endfunction

    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] instret;
    logic             inh_cy;
    logic             inh_ir;

    logic [11:0] addr_p0;
    logic [1:0]  op_p0;
    logic [31:0] wdata_p0;

    logic        hit_cyc_lo;
    logic        hit_cyc_hi;
    logic        hit_ins_lo;
    logic        hit_ins_hi;
    logic        hit_inh;
    logic        is_alias;
    logic        mapped;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        wr_req;
    logic        err;
    logic        commit;
    logic        req_ready_c;
    logic        rsp_valid_c;

    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid)
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // ---- stage p0: request captured on accept ----
    // request fields latched on acceptance; no reset needed, only used in EXEC
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.req_valid) begin
            addr_p0  <= bus.req_addr;
            op_p0    <= bus.req_op;
            wdata_p0 <= bus.req_wdata;
        end
    end

    // address decode and old-value selection for the EXEC cycle
    always_comb begin
        hit_cyc_lo = 1'b0;
        hit_cyc_hi = 1'b0;
        hit_ins_lo = 1'b0;
        hit_ins_hi = 1'b0;
        hit_inh    = 1'b0;
        is_alias   = 1'b0;
        case (addr_p0)
            12'hB00: hit_cyc_lo = 1'b1;
            12'hB80: hit_cyc_hi = 1'b1;
            12'hB02: hit_ins_lo = 1'b1;
            12'hB82: hit_ins_hi = 1'b1;
            12'hC00: begin hit_cyc_lo = 1'b1; is_alias = 1'b1; end
            12'hC80: begin hit_cyc_hi = 1'b1; is_alias = 1'b1; end
            12'hC02: begin hit_ins_lo = 1'b1; is_alias = 1'b1; end
            12'hC82: begin hit_ins_hi = 1'b1; is_alias = 1'b1; end
`ifdef MCOUNTINHIBIT_EN
            12'h320: hit_inh = 1'b1;
`endif
            default: ;
        endcase
        mapped = hit_cyc_lo | hit_cyc_hi | hit_ins_lo | hit_ins_hi | hit_inh;

        old_val = '0;
        if (hit_cyc_lo)
            old_val = cycle[31:0];
        else if (hit_cyc_hi)
            old_val = hi_word_f(cycle);
        else if (hit_ins_lo)
            old_val = instret[31:0];
        else if (hit_ins_hi)
            old_val = hi_word_f(instret);
        else if (hit_inh)
            old_val = {29'd0, inh_ir, 1'b0, inh_cy};

        new_val = rmw_f(op_p0, old_val, wdata_p0);
        wr_req  = is_write_f(op_p0, wdata_p0);
        err     = !mapped || (is_alias && wr_req);
        commit  = (state == ST_EXEC) && wr_req && !err;
    end

    // ---- stage p1: EXEC commit and response capture ----
    // cycle counter: a committed write replaces one half and skips that cycle's increment
    always_ff @(posedge clk) begin
        if (reset)
            cycle <= CYCLE_RST;
        else if (commit && hit_cyc_lo)
            cycle <= {cycle[CNT_W-1:32], new_val};
        else if (commit && hit_cyc_hi)
            cycle <= {new_val[HI_W-1:0], cycle[31:0]};
        else if (!inh_cy)
            cycle <= cycle + CNT_W'(1);
    end

    // instret counter: same collision rule, counts retire pulses
    always_ff @(posedge clk) begin
        if (reset)
            instret <= '0;
        else if (commit && hit_ins_lo)
            instret <= {instret[CNT_W-1:32], new_val};
        else if (commit && hit_ins_hi)
            instret <= {new_val[HI_W-1:0], instret[31:0]};
        else if (instret_inc && !inh_ir)
            instret <= instret + CNT_W'(1);
    end

`ifdef MCOUNTINHIBIT_EN
    // inhibit bits; a new value gates counting from the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (commit && hit_inh) begin
            inh_cy <= new_val[0];
            inh_ir <= new_val[2];
        end
    end
`else
    assign inh_cy = 1'b0;
    assign inh_ir = 1'b0;
`endif

    // response word captured in EXEC and held until the next EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_rdata_q <= err ? 32'd0 : old_val;
            rsp_err_q   <= err;
        end
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit: reset values, read latency, carry
// between halves, write collisions, alias/unmapped errors, response stall,
// reset during a response, and the optional inhibit CSR.
module tb_csr_counter_unit;

    logic clk;
    logic reset;
    logic instret_inc;

    int n_checks;
    int n_fail;

    csr_counter_unit_if bus ();

    csr_counter_unit #(
        .CNT_W     (64),
        .CYCLE_RST (64'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .instret_inc (instret_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction with rsp_ready high. Called #1 after a clock edge.
    // inc_exec drives instret_inc only during the EXEC (commit) cycle.
    task automatic xfer(input  logic [11:0] addr,
                        input  logic [1:0]  op,
                        input  logic [31:0] wdata,
                        input  logic        inc_exec,
                        output logic [31:0] rdata,
                        output logic        err);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_op    = op;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        instret_inc   = inc_exec;
        @(posedge clk); #1;
        instret_inc   = 1'b0;
        check("rsp_valid_lat2", 32'(bus.rsp_valid), 32'd1);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic [31:0] rd2;
    logic        er;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        instret_inc    = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_op     = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'd0);
        check("rst_err", 32'(bus.rsp_err), 32'd0);

        // read 0xC00 on first idle cycle: cycle value during EXEC is 1
        xfer(12'hC00, 2'b00, 32'd0, 1'b0, rd, er);
        check("t1_rdata", rd, 32'd1);
        check("t1_err", 32'(er), 32'd0);

        // carry into high half after writing low half to all ones
        xfer(12'hB80, 2'b00, 32'd0, 1'b0, rd, er);
        check("t2_hi_before", rd, 32'd0);
        xfer(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, rd, er);
        check("t2_rw_old", rd, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        xfer(12'hB80, 2'b00, 32'd0, 1'b0, rd, er);
        check("t2_hi_carry", rd, 32'd1);
        xfer(12'hB00, 2'b00, 32'd0, 1'b0, rd, er);
        check("t2_lo_after_wrap", rd, 32'd6);
        xfer(12'hB80, 2'b01, 32'h0000_ABCD, 1'b0, rd, er);
        check("t2_hi_rw_old", rd, 32'd1);
        xfer(12'hB80, 2'b00, 32'd0, 1'b0, rd, er);
        check("t2_hi_rw_new", rd, 32'h0000_ABCD);

        // instret: count to 3, then set with a retire pulse in the commit cycle
        instret_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        instret_inc = 1'b0;
        xfer(12'hB02, 2'b10, 32'h10, 1'b1, rd, er);
        check("t3_rs_old", rd, 32'h3);
        check("t3_rs_err", 32'(er), 32'd0);
        xfer(12'hB02, 2'b00, 32'd0, 1'b0, rd, er);
        check("t3_rs_new", rd, 32'h13);
        xfer(12'hB02, 2'b11, 32'h3, 1'b0, rd, er);
        check("t3_rc_old", rd, 32'h13);
        xfer(12'hB02, 2'b00, 32'd0, 1'b0, rd, er);
        check("t3_rc_new", rd, 32'h10);
        xfer(12'hC02, 2'b10, 32'd0, 1'b0, rd, er);
        check("t3_alias_rs0_err", 32'(er), 32'd0);
        check("t3_alias_rs0_rd", rd, 32'h10);

        // errors: write to alias, unmapped address
        xfer(12'hC80, 2'b01, 32'd5, 1'b0, rd, er);
        check("t4_alias_wr_err", 32'(er), 32'd1);
        check("t4_alias_wr_rd", rd, 32'd0);
        xfer(12'hB80, 2'b00, 32'd0, 1'b0, rd, er);
        check("t4_hi_unchanged", rd, 32'h0000_ABCD);
        check("t4_hold_vld", 32'(bus.rsp_valid), 32'd0);
        check("t4_hold_rdata", bus.rsp_rdata, 32'h0000_ABCD);
        xfer(12'h7C0, 2'b00, 32'd0, 1'b0, rd, er);
        check("t4_unmapped_err", 32'(er), 32'd1);
        check("t4_unmapped_rd", rd, 32'd0);
        check("t4_hold_err", 32'(bus.rsp_err), 32'd1);

        // response stall, then reset while in RESP
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 12'hB02;
        bus.req_op    = 2'b00;
        bus.req_wdata = 32'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("t5_stall_vld", 32'(bus.rsp_valid), 32'd1);
            check("t5_stall_rdata", bus.rsp_rdata, 32'h10);
            check("t5_stall_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        check("t5_rst_vld", 32'(bus.rsp_valid), 32'd0);
        check("t5_rst_ready", 32'(bus.req_ready), 32'd1);
        check("t5_rst_rdata", bus.rsp_rdata, 32'd0);
        xfer(12'hC00, 2'b00, 32'd0, 1'b0, rd, er);
        check("t5_cycle_reload", rd, 32'd1);
        xfer(12'hB02, 2'b00, 32'd0, 1'b0, rd, er);
        check("t5_instret_reload", rd, 32'd0);

        // inhibit CSR
        xfer(12'h320, 2'b10, 32'd1, 1'b0, rd, er);
`ifdef MCOUNTINHIBIT_EN
        check("t6_inh_err", 32'(er), 32'd0);
        check("t6_inh_old", rd, 32'd0);
        xfer(12'hB00, 2'b00, 32'd0, 1'b0, rd, er);
        xfer(12'hB00, 2'b00, 32'd0, 1'b0, rd2, er);
        check("t6_frozen_a", rd, 32'd8);
        check("t6_frozen_b", rd2, 32'd8);
        xfer(12'h320, 2'b00, 32'd0, 1'b0, rd, er);
        check("t6_inh_read", rd, 32'd1);
`else
        check("t6_inh_absent_err", 32'(er), 32'd1);
        check("t6_inh_absent_rd", rd, 32'd0);
        xfer(12'hB00, 2'b00, 32'd0, 1'b0, rd, er);
        xfer(12'hB00, 2'b00, 32'd0, 1'b0, rd2, er);
        check("t6_running", rd2 - rd, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
